vending_machine_change: RTL and testbench

//  Parametrised successor to the single-price Cola vending FSM.
//  - Accepts half-unit and one-unit coins and vends when credit reaches PRICE.
//  - Returns overpayment as change and supports cancel/refund.
//  - Rejects coins inserted while change is being paid out.
//  - Sits between the coin-acceptor front end and the dispense/change actuators.
//  - All amounts are in half-units: piHalf = 1, piOne = 2.

---
 rtl/vending_machine_change_if.sv | 24 ++
 rtl/vending_machine_change.sv | 113 +++++++++++
 tb/tb_vending_machine_change.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/vending_machine_change_if.sv
// rtl/vending_machine_change_if.sv - coin strobes and vend/change outputs of the vending machine
interface vending_machine_change_if #(
  parameter int CNT_W = 4
);
  logic             piHalf;
  logic             piOne;
  logic             piCancel;
  logic             OCola;
  logic             OChangeOne;
  logic             OChangeHalf;
  logic             OReject;
  logic             OBusy;
  logic [CNT_W-1:0] OCredit;

  modport master (
    output piHalf, piOne, piCancel,
    input  OCola, OChangeOne, OChangeHalf, OReject, OBusy, OCredit
  );

  modport slave (
    input  piHalf, piOne, piCancel,
    output OCola, OChangeOne, OChangeHalf, OReject, OBusy, OCredit
  );
endinterface

// File: rtl/vending_machine_change.sv
// rtl/vending_machine_change.sv - parametrised vending FSM with change return, cancel and coin reject
module vending_machine_change #(
  parameter int PRICE = 5,
  parameter int CNT_W = 4
) (
  input  logic                  sys_clk,
  input  logic                  sysRst,
  vending_machine_change_if.slave bus
);

  typedef enum logic {IDLE, CHANGE} state_t;

  localparam logic [CNT_W-1:0] LP_PRICE = CNT_W'(PRICE);
  localparam logic [CNT_W-1:0] LP_TWO   = CNT_W'(2);
  localparam logic [CNT_W-1:0] LP_ZERO  = '0;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_credit;
  logic [CNT_W-1:0] r_change;
  logic [CNT_W-1:0] w_credit_nxt;
  logic [CNT_W-1:0] w_change_nxt;
  logic [CNT_W-1:0] w_coin;
  logic [CNT_W-1:0] w_sum;
  logic             r_cola;
  logic             r_one;
  logic             r_half;
  logic             r_reject;
  logic             r_busy;
  logic             w_cola_nxt;
  logic             w_one_nxt;
  logic             w_half_nxt;
  logic             w_reject_nxt;
  logic             w_busy_nxt;

  // Coin value in half-units; both strobes together are worth 3.
  assign w_coin = CNT_W'({bus.piOne, bus.piHalf});
  assign w_sum  = r_credit + w_coin;

  // Next-state and next-output decode; every pulse defaults low.
  always_comb begin
    w_state_nxt  = r_state;
    w_credit_nxt = r_credit;
    w_change_nxt = r_change;
    w_cola_nxt   = 1'b0;
    w_one_nxt    = 1'b0;
    w_half_nxt   = 1'b0;
    w_reject_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.piCancel) begin
          // Cancel wins over a vend: everything inserted goes back.
          w_credit_nxt = LP_ZERO;
          w_change_nxt = w_sum;
          if (w_sum != LP_ZERO) w_state_nxt = CHANGE;
        end else if (w_sum >= LP_PRICE) begin
          w_cola_nxt   = 1'b1;
          w_credit_nxt = LP_ZERO;
          w_change_nxt = w_sum - LP_PRICE;
          if (w_sum != LP_PRICE) w_state_nxt = CHANGE;
        end else begin
          w_credit_nxt = w_sum;
        end
      end
      CHANGE: begin
        // Coins cannot be accepted while paying out; cancel is ignored here.
        w_reject_nxt = bus.piHalf | bus.piOne;
        if (r_change >= LP_TWO) begin
          w_one_nxt    = 1'b1;
          w_change_nxt = r_change - LP_TWO;
          if (r_change == LP_TWO) w_state_nxt = IDLE;
        end else begin
          w_half_nxt   = (r_change != LP_ZERO);
          w_change_nxt = LP_ZERO;
          w_state_nxt  = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_busy_nxt = (w_state_nxt == CHANGE);
  end

  // State, counters and registered outputs; reset discards any pending change.
  always_ff @(posedge sys_clk) begin
    if (sysRst) begin
      r_state  <= IDLE;
      r_credit <= LP_ZERO;
      r_change <= LP_ZERO;
      r_cola   <= 1'b0;
      r_one    <= 1'b0;
      r_half   <= 1'b0;
      r_reject <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_credit <= w_credit_nxt;
      r_change <= w_change_nxt;
      r_cola   <= w_cola_nxt;
      r_one    <= w_one_nxt;
      r_half   <= w_half_nxt;
      r_reject <= w_reject_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign bus.OCola       = r_cola;
  assign bus.OChangeOne  = r_one;
  assign bus.OChangeHalf = r_half;
  assign bus.OReject     = r_reject;
  assign bus.OBusy       = r_busy;
  assign bus.OCredit     = r_credit;

endmodule

// File: tb/tb_vending_machine_change.sv
// tb/tb_vending_machine_change.sv - directed self-checking bench for vending_machine_change
module tb_vending_machine_change;

  logic sys_clk = 1'b0;
  logic sysRst  = 1'b1;
  logic r_h = 1'b0;
  logic r_o = 1'b0;
  logic r_c = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   busy_cnt;

  vending_machine_change_if #(.CNT_W(4)) ifa ();
  vending_machine_change_if #(.CNT_W(4)) ifb ();

  assign ifa.piHalf   = r_h;
  assign ifa.piOne    = r_o;
  assign ifa.piCancel = r_c;
  assign ifb.piHalf   = r_h;
  assign ifb.piOne    = r_o;
  assign ifb.piCancel = r_c;

  vending_machine_change #(.PRICE(5), .CNT_W(4)) u_dut5 (
    .sys_clk (sys_clk),
    .sysRst  (sysRst),
    .bus     (ifa.slave)
  );

  vending_machine_change #(.PRICE(7), .CNT_W(4)) u_dut7 (
    .sys_clk (sys_clk),
    .sysRst  (sysRst),
    .bus     (ifb.slave)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock with the given strobes; outputs are then read 1 time unit after the edge.
  task automatic cyc(input logic h, input logic o, input logic c);
    r_h = h;
    r_o = o;
    r_c = c;
    @(posedge sys_clk);
    #1;
    r_h = 1'b0;
    r_o = 1'b0;
    r_c = 1'b0;
  endtask

  task automatic chk_a(input string tag, input int cola, input int one, input int half,
                       input int rej, input int busy, input int credit);
    chk({tag, ".cola"},   int'(ifa.OCola),       cola);
    chk({tag, ".one"},    int'(ifa.OChangeOne),  one);
    chk({tag, ".half"},   int'(ifa.OChangeHalf), half);
    chk({tag, ".rej"},    int'(ifa.OReject),     rej);
    chk({tag, ".busy"},   int'(ifa.OBusy),       busy);
    chk({tag, ".credit"}, int'(ifa.OCredit),     credit);
  endtask

  initial begin
    // Reset state
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    sysRst = 1'b0;
    chk_a("rst", 0, 0, 0, 0, 0, 0);

    // Exact pay: one, one, half
    cyc(1'b0, 1'b1, 1'b0); chk_a("t2.c1", 0, 0, 0, 0, 0, 2);
    cyc(1'b0, 1'b1, 1'b0); chk_a("t2.c2", 0, 0, 0, 0, 0, 4);
    cyc(1'b1, 1'b0, 1'b0); chk_a("t2.c3", 1, 0, 0, 0, 0, 0);
    cyc(1'b0, 1'b0, 1'b0); chk_a("t2.idle", 0, 0, 0, 0, 0, 0);

    // Overpay: half, one, one lands exactly on price
    cyc(1'b1, 1'b0, 1'b0); chk_a("t3a.c1", 0, 0, 0, 0, 0, 1);
    cyc(1'b0, 1'b1, 1'b0); chk_a("t3a.c2", 0, 0, 0, 0, 0, 3);
    cyc(1'b0, 1'b1, 1'b0); chk_a("t3a.c3", 1, 0, 0, 0, 0, 0);
    // one, one, one: vend with one half-unit change
    cyc(1'b0, 1'b1, 1'b0); chk_a("t3b.c1", 0, 0, 0, 0, 0, 2);
    cyc(1'b0, 1'b1, 1'b0); chk_a("t3b.c2", 0, 0, 0, 0, 0, 4);
    cyc(1'b0, 1'b1, 1'b0); chk_a("t3b.c3", 1, 0, 0, 0, 1, 0);
    cyc(1'b0, 1'b0, 1'b0); chk_a("t3b.chg", 0, 0, 1, 0, 0, 0);
    cyc(1'b0, 1'b0, 1'b0); chk_a("t3b.end", 0, 0, 0, 0, 0, 0);

    // Both strobes at credit 4: s=7, change 2
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0); chk_a("t4.c2", 0, 0, 0, 0, 0, 4);
    cyc(1'b1, 1'b1, 1'b0); chk_a("t4.both", 1, 0, 0, 0, 1, 0);
    cyc(1'b0, 1'b0, 1'b0); chk_a("t4.chg", 0, 1, 0, 0, 0, 0);
    cyc(1'b0, 1'b0, 1'b0); chk_a("t4.end", 0, 0, 0, 0, 0, 0);

    // Cancel at credit 4 with simultaneous half: refund 5 as one, one, half
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1); chk_a("t5.cancel", 0, 0, 0, 0, 1, 0);
    busy_cnt = int'(ifa.OBusy);
    cyc(1'b0, 1'b0, 1'b0); chk_a("t5.p1", 0, 1, 0, 0, 1, 0);
    busy_cnt += int'(ifa.OBusy);
    cyc(1'b0, 1'b0, 1'b0); chk_a("t5.p2", 0, 1, 0, 0, 1, 0);
    busy_cnt += int'(ifa.OBusy);
    cyc(1'b0, 1'b0, 1'b0); chk_a("t5.p3", 0, 0, 1, 0, 0, 0);
    busy_cnt += int'(ifa.OBusy);
    chk("t5.busy_cycles", busy_cnt, 3);
    cyc(1'b0, 1'b0, 1'b0); chk_a("t5.end", 0, 0, 0, 0, 0, 0);

    // Coin during CHANGE is rejected and does not disturb the payout
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1); chk_a("t6.cancel", 0, 0, 0, 0, 1, 0);
    cyc(1'b0, 1'b1, 1'b0); chk_a("t6.rej", 0, 1, 0, 1, 1, 0);
    cyc(1'b0, 1'b0, 1'b0); chk_a("t6.p2", 0, 1, 0, 0, 0, 0);
    cyc(1'b0, 1'b0, 1'b0); chk_a("t6.end", 0, 0, 0, 0, 0, 0);

    // Cancel with nothing inserted does nothing
    cyc(1'b0, 1'b0, 1'b1); chk_a("cancel0", 0, 0, 0, 0, 0, 0);

    // Reset mid-CHANGE with change 3 discards the rest
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1); chk_a("t1.cancel", 0, 0, 0, 0, 1, 0);
    sysRst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0); chk_a("t1.rst", 0, 0, 0, 0, 0, 0);
    sysRst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0); chk_a("t1.after1", 0, 0, 0, 0, 0, 0);
    cyc(1'b0, 1'b0, 1'b0); chk_a("t1.after2", 0, 0, 0, 0, 0, 0);

    // PRICE=7: one, one, half no longer vends; one more one does (s=7)
    cyc(1'b0, 1'b1, 1'b0); chk("p7.c1.credit", int'(ifb.OCredit), 2);
    cyc(1'b0, 1'b1, 1'b0); chk("p7.c2.credit", int'(ifb.OCredit), 4);
    cyc(1'b1, 1'b0, 1'b0);
    chk("p7.c3.credit", int'(ifb.OCredit), 5);
    chk("p7.c3.cola",   int'(ifb.OCola),   0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("p7.c4.cola",   int'(ifb.OCola),   1);
    chk("p7.c4.busy",   int'(ifb.OBusy),   0);
    chk("p7.c4.credit", int'(ifb.OCredit), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Change denominations are never paid in the same cycle.
  always @(negedge sys_clk) begin
    if (ifa.OChangeOne && ifa.OChangeHalf) begin
      total++;
      bad++;
      $display("FAIL both_change: got 1 expected 0");
    end
  end

endmodule
